// File: rtl/wb_stage_ecall_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_ecall_pkg
//  Description : Shared types and constants for the ECALL-capable WB stage.
//  Revision    : 1.0
// ============================================================================
package wb_stage_ecall_pkg;

    localparam int c_ECALL_NUM_IDX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wb_ecall_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       en_rd;
        logic       is_load;
        logic       is_store;
        logic       is_csr;
        logic       is_atomic;
        logic       is_ecall;
    } decoded_inst_t;

    function automatic logic uses_mem_result(input decoded_inst_t inst);
        return inst.is_load || inst.is_store || inst.is_csr || inst.is_atomic;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ecall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ecall_ctrl
//  Description : ECALL request/ack FSM, argument snapshot, return latch and
//                serviced-call counter.
//  Revision    : 1.0
// ============================================================================
module wb_ecall_ctrl
    import wb_stage_ecall_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int NARGS         = 8,
    parameter int ECALL_NUM_IDX = c_ECALL_NUM_IDX,
    parameter int CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_ecall,
    input  logic [NARGS-1:0][XLEN-1:0]  args,
    input  logic                        ecall_ack,
    input  logic [XLEN-1:0]             ecall_ret,
    output logic                        ecall_req,
    output logic [XLEN-1:0]             ecall_num,
    output logic [NARGS-1:0][XLEN-1:0]  ecall_args,
    output logic                        stall_req,
    output logic [XLEN-1:0]             ret_q,
    output logic                        in_done,
    output logic [CNT_W-1:0]            ecall_count
);

    wb_ecall_state_t            r_state;
    wb_ecall_state_t            w_state_next;
    logic                       r_ecall_req;
    logic [XLEN-1:0]            r_ecall_num;
    logic [NARGS-1:0][XLEN-1:0] r_ecall_args;
    logic [XLEN-1:0]            r_ret_q;
    logic [CNT_W-1:0]           r_ecall_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (valid_ecall) w_state_next = REQ;
            REQ:     if (ecall_ack)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ecall_req is registered from the next state so it is high exactly in REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ecall_req   <= 1'b0;
            r_ecall_num   <= '0;
            r_ecall_args  <= '0;
            r_ret_q       <= '0;
            r_ecall_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ecall_req <= (w_state_next == REQ);
            if ((r_state == IDLE) && valid_ecall) begin
                r_ecall_args <= args;
                r_ecall_num  <= args[ECALL_NUM_IDX];
            end
            if ((r_state == REQ) && ecall_ack) begin
                r_ret_q       <= ecall_ret;
                r_ecall_count <= r_ecall_count + CNT_W'(1);
            end
        end
    end

    assign ecall_req   = r_ecall_req;
    assign ecall_num   = r_ecall_num;
    assign ecall_args  = r_ecall_args;
    assign ret_q       = r_ret_q;
    assign ecall_count = r_ecall_count;
    assign stall_req   = ((r_state == IDLE) && valid_ecall) || (r_state == REQ);
    assign in_done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: rtl/wb_stage_ecall.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_ecall
//  Description : Writeback stage with result mux, register-file write gating
//                and handshake-based ECALL servicing.
//  Revision    : 1.0
// ============================================================================
module wb_stage_ecall
    import wb_stage_ecall_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int NARGS         = 8,
    parameter int ECALL_NUM_IDX = c_ECALL_NUM_IDX,
    parameter int CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        is_bubble,
    input  decoded_inst_t               inst,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             mem_result,
    input  logic [NARGS-1:0][XLEN-1:0]  args,
    output logic                        ecall_req,
    output logic [XLEN-1:0]             ecall_num,
    output logic [NARGS-1:0][XLEN-1:0]  ecall_args,
    input  logic                        ecall_ack,
    input  logic [XLEN-1:0]             ecall_ret,
    output logic [XLEN-1:0]             result,
    output logic [4:0]                  rd,
    output logic                        en_rd,
    output logic                        stall,
    output logic                        retire,
    output logic [CNT_W-1:0]            ecall_count
);

    logic            w_valid_ecall;
    logic            w_stall_req;
    logic            w_in_done;
    logic            w_commit_ok;
    logic [XLEN-1:0] w_ret_q;

    assign w_valid_ecall = inst.is_ecall && !is_bubble;

    wb_ecall_ctrl #(
        .XLEN          (XLEN),
        .NARGS         (NARGS),
        .ECALL_NUM_IDX (ECALL_NUM_IDX),
        .CNT_W         (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .valid_ecall (w_valid_ecall),
        .args        (args),
        .ecall_ack   (ecall_ack),
        .ecall_ret   (ecall_ret),
        .ecall_req   (ecall_req),
        .ecall_num   (ecall_num),
        .ecall_args  (ecall_args),
        .stall_req   (w_stall_req),
        .ret_q       (w_ret_q),
        .in_done     (w_in_done),
        .ecall_count (ecall_count)
    );

    always_comb begin
        result = alu_result;
        if (uses_mem_result(inst)) begin
            result = mem_result;
        end else if (inst.is_ecall) begin
            result = w_ret_q;
        end
    end

    // An ECALL is only unstalled in DONE, so it commits exactly there.
    assign w_commit_ok = inst.is_ecall ? w_in_done : !w_stall_req;

    assign stall  = w_stall_req;
    assign rd     = inst.rd;
    assign en_rd  = inst.en_rd && !is_bubble && w_commit_ok;
    assign retire = !is_bubble && w_commit_ok;

endmodule
`default_nettype wire
